id_issue_ctrl: RTL

//  ID-stage pipeline register and issue controller for the 5-stage core.
//  - Latches {pc, inst} from IF and presents it to the decoder.
//  - Consumes the RAW-hazard flag from the data hazard detector and holds the

---
 rtl/id_issue_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/id_issue_ctrl.sv
// ID-stage pipeline register and issue controller: holds {pc, inst} from IF, stalls on RAW hazards, drops on flush.
// Optional feature macro: ID_STALL_CNT_EN builds a 32-bit total-stall-cycle counter on stall_cnt.
//
// state | meaning
// EMPTY | no live instruction in ID
// VALID | live instruction, free to issue when EX allows
// STALL | live instruction held by a RAW hazard
module id_issue_ctrl #(
    parameter int PC_W        = 32,
    parameter int INST_W      = 32,
    parameter int STALL_LIMIT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fs_to_ds_valid,
    input  logic [PC_W+INST_W-1:0] fs_to_ds_bus,
    output logic                   ds_allowin,
    input  logic                   hazard_occur,
    input  logic                   es_allowin,
    input  logic                   flush,
    output logic [PC_W-1:0]        ds_pc,
    output logic [INST_W-1:0]      ds_inst,
    output logic                   ds_valid,
    output logic                   ds_to_es_valid,
    output logic                   stall_timeout,
    output logic [31:0]            stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        VALID = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

    state_t                   state_q;
    state_t                   state_d;
    logic [PC_W+INST_W-1:0]   payload_q;
    logic [15:0]              age_q;
    logic [15:0]              age_d;
    logic                     timeout_q;
    logic                     ready_go;
    logic                     capture;
    logic                     issue;
    logic                     stalling;

    assign ds_valid       = (state_q != EMPTY);
    assign ready_go       = ~hazard_occur;
    assign ds_allowin     = ~ds_valid | (ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid & ready_go & ~flush;
    assign capture        = fs_to_ds_valid & ds_allowin & ~flush;
    assign issue          = ds_to_es_valid & es_allowin;
    assign stalling       = ds_valid & hazard_occur;

    assign {ds_pc, ds_inst} = payload_q;
    assign stall_timeout    = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // STALL with the hazard gone behaves exactly like VALID in the same cycle.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (capture) state_d = VALID;
                end
                VALID, STALL: begin
                    if (hazard_occur) begin
                        state_d = STALL;
                    end else if (es_allowin) begin
                        state_d = capture ? VALID : EMPTY;
                    end else begin
                        state_d = VALID;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            payload_q <= '0;
        end else if (capture) begin
            payload_q <= fs_to_ds_bus;
        end
    end

    always_comb begin
        age_d = age_q;
        if (flush || issue) begin
            age_d = '0;
        end else if (stalling && (age_q != 16'hFFFF)) begin
            age_d = age_q + 16'd1;
        end
    end

    // Timeout is set on the same edge the age reaches the limit, so both are visible together.
    always_ff @(posedge clk) begin
        if (reset) begin
            age_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            age_q <= age_d;
            if (age_d >= LIMIT) timeout_q <= 1'b1;
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stalling && !flush) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule
